// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised Moore serial-pattern detector.
// Holds the KMP failure-function and next-state-table builders. Both are
// evaluated at elaboration time from the pattern parameters, so the detector
// carries no runtime pattern-matching logic.
package seq_det_pkg;

    localparam int MAX_SEQ_LEN = 16;
    localparam int STATE_W     = $clog2(MAX_SEQ_LEN + 1);

    typedef logic [STATE_W-1:0]        state_t;
    typedef state_t [MAX_SEQ_LEN:0]      pi_tbl_t;
    typedef state_t [MAX_SEQ_LEN:0][1:0] next_tbl_t;

    // Pattern bit i in arrival order: bit 0 is the MSB of the pattern.
    function automatic logic pat_bit(input int seq_len,
                                     input logic [MAX_SEQ_LEN-1:0] seq,
                                     input int i);
        logic [MAX_SEQ_LEN-1:0] t;
        t = seq >> (seq_len - 1 - i);
        return t[0];
    endfunction

    // pi(s): length of the longest proper prefix of P[0..s-1] that is also
    // a suffix of it. Brute force is fine; this only runs at elaboration.
    function automatic pi_tbl_t calc_pi(input int seq_len,
                                        input logic [MAX_SEQ_LEN-1:0] seq);
        pi_tbl_t pi;
        logic    eq;
        pi = '0;
        for (int s = 2; s <= seq_len; s++) begin
            for (int k = 1; k < s; k++) begin
                eq = 1'b1;
                for (int j = 0; j < k; j++) begin
                    if (pat_bit(seq_len, seq, j) != pat_bit(seq_len, seq, s - k + j))
                        eq = 1'b0;
                end
                // Ascending k: the last hit is the longest border.
                if (eq)
                    pi[s] = state_t'(k);
            end
        end
        return pi;
    endfunction

    // Next-state table d(s,b). Row SEQ_LEN holds the overlapping exit from
    // MATCH, d(pi(SEQ_LEN),b); the non-overlapping exit reuses row 0.
    // Rows are filled in ascending order, so d(pi(s),b) is always ready.
    function automatic next_tbl_t calc_next(input int seq_len,
                                            input logic [MAX_SEQ_LEN-1:0] seq);
        next_tbl_t nt;
        pi_tbl_t   pi;
        nt = '0;
        pi = calc_pi(seq_len, seq);
        for (int s = 0; s <= seq_len; s++) begin
            for (int b = 0; b < 2; b++) begin
                if (s < seq_len && pat_bit(seq_len, seq, s) == 1'(b))
                    nt[s][b] = state_t'(s + 1);
                else if (s == 0)
                    nt[s][b] = '0;
                else
                    nt[s][b] = nt[pi[s]][b];
            end
        end
        return nt;
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear. Clear has priority over
// increment; the count sticks at all-ones instead of wrapping.
module seq_det_sat_cnt
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Count register: reset/clear to zero, otherwise increment until full.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && cnt != CNT_MAX)
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/moore_seq_detector_param.sv
// Parametrised Moore serial-pattern detector.
// State s = number of pattern bits currently matched; state SEQ_LEN is MATCH.
// Transitions come from a table built at elaboration (KMP automaton).
// ovl selects overlapping/non-overlapping restart when leaving MATCH.
// Optional match counter enabled by defining MOORE_SEQ_DET_CNT_EN; without
// it match_cnt is tied to zero and cnt_clr is ignored.
module moore_seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 SEQ_LEN  = 4,
    parameter logic [SEQ_LEN-1:0] SEQUENCE = 4'b1001,
    parameter int                 CNT_W    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         x_vld,
    input  logic                         x,
    input  logic                         ovl,
    input  logic                         cnt_clr,
    output logic                         z,
    output logic [$clog2(SEQ_LEN+1)-1:0] depth,
    output logic [CNT_W-1:0]             match_cnt
);

    localparam int DEPTH_W = $clog2(SEQ_LEN + 1);

    localparam logic [STATE_W-1:0] ST_IDLE  = '0;
    localparam logic [STATE_W-1:0] ST_MATCH = STATE_W'(SEQ_LEN);

    localparam next_tbl_t NEXT_TBL = calc_next(SEQ_LEN, MAX_SEQ_LEN'(SEQUENCE));

    state_t state;
    state_t state_nxt;

    // Next state: hold on invalid input, otherwise table lookup; the MATCH
    // exit picks the overlapping row or restarts from idle based on ovl.
    always_comb begin
        state_nxt = state;
        if (x_vld) begin
            if (state == ST_MATCH)
                state_nxt = ovl ? NEXT_TBL[ST_MATCH][x] : NEXT_TBL[ST_IDLE][x];
            else
                state_nxt = NEXT_TBL[state][x];
        end
    end

    // State register; reset discards any partial match.
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Moore outputs decode the state register only.
    assign z     = (state == ST_MATCH);
    assign depth = DEPTH_W'(state);

`ifdef MOORE_SEQ_DET_CNT_EN
    // A held MATCH (x_vld=0) keeps state_nxt==MATCH but must not recount,
    // so only valid edges landing in MATCH increment.
    logic cnt_inc;
    assign cnt_inc = x_vld && (state_nxt == ST_MATCH);

    seq_det_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_sat_cnt (
        .clk (clk),
        .rst (rst),
        .inc (cnt_inc),
        .clr (cnt_clr),
        .cnt (match_cnt)
    );
`else
    logic cnt_clr_unused;
    assign cnt_clr_unused = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_moore_seq_detector_param.sv
// Directed bench for moore_seq_detector_param. Three instances share the
// stimulus: a (defaults, 1001), b (1001, CNT_W=2), c (SEQ_LEN=5, 11011).
// Only the instance relevant to each phase is checked. Counter expectations
// follow MOORE_SEQ_DET_CNT_EN (zero when the counter is not built).
module tb_moore_seq_detector_param;

`ifdef MOORE_SEQ_DET_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    logic x_vld;
    logic x;
    logic ovl;
    logic cnt_clr;

    logic       a_z, b_z, c_z;
    logic [2:0] a_depth, b_depth, c_depth;
    logic [7:0] a_cnt, c_cnt;
    logic [1:0] b_cnt;

    int checks   = 0;
    int failures = 0;

    moore_seq_detector_param u_a (
        .clk(clk), .rst(rst), .x_vld(x_vld), .x(x), .ovl(ovl), .cnt_clr(cnt_clr),
        .z(a_z), .depth(a_depth), .match_cnt(a_cnt)
    );

    moore_seq_detector_param #(.SEQ_LEN(4), .SEQUENCE(4'b1001), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .x_vld(x_vld), .x(x), .ovl(ovl), .cnt_clr(cnt_clr),
        .z(b_z), .depth(b_depth), .match_cnt(b_cnt)
    );

    moore_seq_detector_param #(.SEQ_LEN(5), .SEQUENCE(5'b11011), .CNT_W(8)) u_c (
        .clk(clk), .rst(rst), .x_vld(x_vld), .x(x), .ovl(ovl), .cnt_clr(cnt_clr),
        .z(c_z), .depth(c_depth), .match_cnt(c_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ecnt(input int v);
        return CNT_EN ? 32'(v) : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one bit, clock it in, sample 1 time unit after the edge.
    task automatic step(input logic v, input logic b);
        x_vld = v;
        x     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input int d);
        check({tag, ".depth"}, 32'(a_depth), 32'(d));
        check({tag, ".z"}, 32'(a_z), 32'(d == 4));
    endtask

    task automatic check_c(input string tag, input int d);
        check({tag, ".depth"}, 32'(c_depth), 32'(d));
        check({tag, ".z"}, 32'(c_z), 32'(d == 5));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        logic [6:0] s1;
        logic [7:0] s6;
        int d1 [7];
        int d2 [7];
        int d6o [8];
        int d6n [8];

        s1  = 7'b1001001;
        s6  = 8'b11011011;
        d1  = '{1, 2, 3, 4, 2, 3, 4};
        d2  = '{1, 2, 3, 4, 0, 0, 1};
        d6o = '{1, 2, 3, 4, 5, 3, 4, 5};
        d6n = '{1, 2, 3, 4, 5, 0, 1, 2};

        rst = 1'b1; x_vld = 1'b0; x = 1'b0; ovl = 1'b1; cnt_clr = 1'b0;

        // Reset state
        step(1'b0, 1'b0);
        check_a("reset", 0);
        check("reset.cnt", 32'(a_cnt), 32'd0);
        rst = 1'b0;

        // Overlapping, 1001001
        ovl = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, s1[6-i]);
            check_a($sformatf("ovl1.bit%0d", i + 1), d1[i]);
        end
        check("ovl1.cnt", 32'(a_cnt), ecnt(2));

        // Non-overlapping, same stream
        do_reset();
        ovl = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, s1[6-i]);
            check_a($sformatf("ovl0.bit%0d", i + 1), d2[i]);
        end
        check("ovl0.cnt", 32'(a_cnt), ecnt(1));

        // Invalid cycles between bits 2 and 3, then held MATCH
        do_reset();
        ovl = 1'b1;
        step(1'b1, 1'b1); check_a("vld.b1", 1);
        step(1'b1, 1'b0); check_a("vld.b2", 2);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            check_a($sformatf("vld.gap%0d", i), 2);
        end
        step(1'b1, 1'b0); check_a("vld.b3", 3);
        step(1'b1, 1'b1); check_a("vld.b4", 4);
        step(1'b1, 1'b0); check_a("vld.b5", 2);
        step(1'b1, 1'b0); check_a("vld.b6", 3);
        step(1'b1, 1'b1); check_a("vld.b7", 4);
        step(1'b0, 1'b0); check_a("vld.hold1", 4);
        step(1'b0, 1'b1); check_a("vld.hold2", 4);
        check("vld.hold.cnt", 32'(a_cnt), ecnt(2));

        // Reset mid-sequence
        do_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check_a("rst.pre", 3);
        rst = 1'b1;
        step(1'b1, 1'b1);
        check_a("rst.during", 0);
        check("rst.during.cnt", 32'(a_cnt), 32'd0);
        rst = 1'b0;
        step(1'b1, 1'b1);
        check_a("rst.after", 1);
        check("rst.after.cnt", 32'(a_cnt), 32'd0);

        // Saturating 2-bit counter, non-overlapping
        do_reset();
        ovl = 1'b0;
        for (int m = 1; m <= 5; m++) begin
            step(1'b1, 1'b1);
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
            step(1'b1, 1'b1);
            check($sformatf("sat.m%0d.depth", m), 32'(b_depth), 32'd4);
            check($sformatf("sat.m%0d.z", m), 32'(b_z), 32'd1);
            check($sformatf("sat.m%0d.cnt", m), 32'(b_cnt), ecnt(m < 3 ? m : 3));
        end
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        cnt_clr = 1'b1;
        step(1'b1, 1'b1);
        cnt_clr = 1'b0;
        check("sat.clr.depth", 32'(b_depth), 32'd4);
        check("sat.clr.cnt", 32'(b_cnt), 32'd0);

        // SEQ_LEN=5, 11011, overlapping
        do_reset();
        ovl = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, s6[7-i]);
            check_c($sformatf("len5o.bit%0d", i + 1), d6o[i]);
        end
        check("len5o.cnt", 32'(c_cnt), ecnt(2));

        // SEQ_LEN=5, non-overlapping
        do_reset();
        ovl = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, s6[7-i]);
            check_c($sformatf("len5n.bit%0d", i + 1), d6n[i]);
        end
        check("len5n.cnt", 32'(c_cnt), ecnt(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
